// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// StAbort is only reachable in builds with WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGranted = 2'd1,
    StAbort   = 2'd2
  } arb_state_e;

  // Index width for an N-entry vector; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin chooser.
// Selects the first asserted request at or after i_ptr, wrapping modulo N_REQ.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]               i_req,
  input  logic [idx_width(N_REQ)-1:0]    i_ptr,
  output logic [N_REQ-1:0]               o_pick,
  output logic                           o_valid
);

  localparam int unsigned IdxW = idx_width(N_REQ);

  logic [IdxW-1:0] w_idx;

  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      w_idx = IdxW'((32'(i_ptr) + off) % N_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among N_REQ controllers.
// Define WB_ARB_TIMEOUT_EN to add the no-ack watchdog with a one-cycle abort/err.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_cyc_i,
  input  logic [N_REQ-1:0]              req_stb_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_dat_i,
  output logic [N_REQ-1:0]              req_stall_o,
  output logic [N_REQ-1:0]              req_ack_o,
  output logic [N_REQ-1:0]              req_err_o,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic [DATA_WIDTH-1:0]         dat_o,
  input  logic                          stall_i,
  input  logic                          ack_i,
  output logic [N_REQ-1:0]              grant_o
);

  localparam int unsigned IdxW = idx_width(N_REQ);

  arb_state_e       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IdxW-1:0]  r_ptr;
  logic [IdxW-1:0]  r_gidx;

  logic [N_REQ-1:0] w_pick;
  logic             w_pick_valid;
  logic [IdxW-1:0]  w_pick_idx;
  logic [IdxW-1:0]  w_ptr_nxt;
  logic             w_g_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] r_wdog;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (req_cyc_i),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_pick[k]) w_pick_idx = IdxW'(k);
    end
  end

  assign w_ptr_nxt = (r_gidx == IdxW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
  assign w_g_cyc   = req_cyc_i[r_gidx];
  assign grant_o   = r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_ptr   <= '0;
      r_gidx  <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      r_wdog  <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
`ifdef WB_ARB_TIMEOUT_EN
          r_wdog <= '0;
`endif
          if (w_pick_valid) begin
            r_state <= StGranted;
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
          end
        end
        StGranted: begin
          if (!w_g_cyc) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (ack_i) begin
            r_wdog <= '0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
            if (r_wdog == WdogW'(TIMEOUT_CYCLES - 1)) r_state <= StAbort;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        StAbort: begin
          r_state <= StIdle;
          r_grant <= '0;
          r_ptr   <= w_ptr_nxt;
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  // Non-granted strobes are always stalled so they hold their request
  always_comb begin
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    dat_o       = '0;
    req_ack_o   = '0;
    req_err_o   = '0;
    req_stall_o = req_cyc_i & req_stb_i;
    if (r_state == StGranted) begin
      cyc_o               = w_g_cyc;
      stb_o               = req_stb_i[r_gidx];
      req_stall_o[r_gidx] = stall_i;
      req_ack_o[r_gidx]   = ack_i & w_g_cyc;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (IdxW'(k) == r_gidx) dat_o = req_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (r_state == StAbort) begin
      req_err_o[r_gidx]   = 1'b1;
      req_stall_o[r_gidx] = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: expected grants and acks are queued by the
// stimulus and popped by a negedge monitor; timeout scenario needs WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_cyc_i;
  logic [3:0]  req_stb_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_stall_o;
  logic [3:0]  req_ack_o;
  logic [3:0]  req_err_o;
  logic        cyc_o;
  logic        stb_o;
  logic [7:0]  dat_o;
  logic        stall_i;
  logic        ack_i;
  logic [3:0]  grant_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] q_grant[$];
  logic [3:0] q_ack[$];
  logic [3:0] prev_grant = '0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .N_REQ          (4),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_cyc_i   (req_cyc_i),
    .req_stb_i   (req_stb_i),
    .req_dat_i   (req_dat_i),
    .req_stall_o (req_stall_o),
    .req_ack_o   (req_ack_o),
    .req_err_o   (req_err_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .dat_o       (dat_o),
    .stall_i     (stall_i),
    .ack_i       (ack_i),
    .grant_o     (grant_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every new grant and every ack pulse must match the next queued expectation
  always @(negedge clk) begin
    if (req_ack_o != 4'b0) begin
      if (q_ack.size() == 0) chk("ack_unexpected", 32'(req_ack_o), 32'd0);
      else chk("ack_vec", 32'(req_ack_o), 32'(q_ack.pop_front()));
    end
    if (grant_o != 4'b0 && grant_o != prev_grant) begin
      if (q_grant.size() == 0) chk("grant_unexpected", 32'(grant_o), 32'd0);
      else chk("grant_seq", 32'(grant_o), 32'(q_grant.pop_front()));
    end
    prev_grant <= grant_o;
  end

  task automatic wait_grant(input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (grant_o != 4'b0) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_wait: got no grant expected one within %0d cycles", max);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_cyc_i = 4'b0101;
    req_stb_i = 4'b0100;
    req_dat_i = '0;
    stall_i   = 1'b0;
    ack_i     = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_ack", 32'(req_ack_o), 32'd0);
    chk("rst_err", 32'(req_err_o), 32'd0);
    chk("rst_stall", 32'(req_stall_o), 32'h4);
    @(posedge clk); #1;
    req_cyc_i = '0;
    req_stb_i = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("idle_cyc", 32'(cyc_o), 32'd0);
    chk("idle_grant", 32'(grant_o), 32'd0);
  endtask

  // One write from requester k: nst stalled cycles, accept, ack, then release cyc
  task automatic serve(input int k, input logic [7:0] exp_dat, input int nst, input bit reraise);
    logic [3:0] mask;
    mask    = 4'(1) << k;
    stall_i = (nst != 0);
    wait_grant(8);
    chk("grant_onehot", 32'(grant_o), 32'(mask));
    chk("cyc_on_grant", 32'(cyc_o), 32'd1);
    chk("dat_o", 32'(dat_o), 32'(exp_dat));
    for (int i = 0; i < nst; i++) begin
      chk("stall_all", 32'(req_stall_o), 32'(req_cyc_i & req_stb_i));
      @(posedge clk); #1;
      if (i == nst - 1) stall_i = 1'b0;
      @(negedge clk);
    end
    chk("stall_others", 32'(req_stall_o), 32'(req_cyc_i & req_stb_i & ~mask));
    @(posedge clk); #1;
    ack_i     = 1'b1;
    req_stb_i = req_stb_i & ~mask;
    q_ack.push_back(mask);
    @(posedge clk); #1;
    ack_i     = 1'b0;
    req_cyc_i = req_cyc_i & ~mask;
    @(posedge clk); #1;
    if (reraise) begin
      req_cyc_i = req_cyc_i | mask;
      req_stb_i = req_stb_i | mask;
    end
    @(negedge clk);
    chk("idle_gap", {27'd0, grant_o, cyc_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single transfer from requester 1 with two stall cycles
    @(posedge clk); #1;
    req_dat_i = 32'h0000_A500;
    req_cyc_i = 4'b0010;
    req_stb_i = 4'b0010;
    q_grant.push_back(4'b0010);
    @(negedge clk);
    chk("latency_grant", 32'(grant_o), 32'd0);
    chk("latency_cyc", 32'(cyc_o), 32'd0);
    chk("latency_stall", 32'(req_stall_o), 32'h2);
    serve(1, 8'hA5, 2, 1'b0);

    // Pointer now 2: requests {0,3} must pick 3 first, then 0
    @(posedge clk); #1;
    req_dat_i = 32'h3322_11C0;
    req_cyc_i = 4'b1001;
    req_stb_i = 4'b1001;
    q_grant.push_back(4'b1000);
    q_grant.push_back(4'b0001);
    serve(3, 8'h33, 1, 1'b0);
    serve(0, 8'hC0, 0, 1'b0);

    // Fairness: all four hold cyc, requester 0 re-requests after its turn
    do_reset();
    @(posedge clk); #1;
    req_dat_i = 32'h1312_1110;
    req_cyc_i = 4'b1111;
    req_stb_i = 4'b1111;
    q_grant.push_back(4'b0001);
    q_grant.push_back(4'b0010);
    q_grant.push_back(4'b0100);
    q_grant.push_back(4'b1000);
    q_grant.push_back(4'b0001);
    serve(0, 8'h10, 0, 1'b1);
    serve(1, 8'h11, 0, 1'b0);
    serve(2, 8'h12, 1, 1'b0);
    serve(3, 8'h13, 0, 1'b0);
    serve(0, 8'h10, 0, 1'b0);

    // Contention: requester 2 strobes while 0 owns the bus, then skips past idle 1
    do_reset();
    @(posedge clk); #1;
    req_dat_i = 32'h0055_0044;
    req_cyc_i = 4'b0101;
    req_stb_i = 4'b0101;
    q_grant.push_back(4'b0001);
    q_grant.push_back(4'b0100);
    serve(0, 8'h44, 3, 1'b0);
    serve(2, 8'h55, 0, 1'b0);

    // Async reset while requester 2 is acked (pointer was 3 before reset)
    @(posedge clk); #1;
    req_dat_i = 32'h0066_0000;
    req_cyc_i = 4'b0100;
    req_stb_i = 4'b0100;
    q_grant.push_back(4'b0100);
    wait_grant(4);
    chk("pre_rst_grant", 32'(grant_o), 32'h4);
    @(posedge clk); #1;
    ack_i = 1'b1;
    q_ack.push_back(4'b0100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(cyc_o), 32'd0);
    chk("async_rst_grant", 32'(grant_o), 32'd0);
    chk("async_rst_ack", 32'(req_ack_o), 32'd0);
    ack_i     = 1'b0;
    req_cyc_i = '0;
    req_stb_i = '0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_cyc_i = 4'b1010;
    req_stb_i = 4'b1010;
    q_grant.push_back(4'b0010);
    wait_grant(4);
    chk("ptr_after_reset", 32'(grant_o), 32'h2);
    @(posedge clk); #1;
    req_cyc_i = '0;
    req_stb_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Stray ack and stb without cyc while idle must be ignored
    req_stb_i = 4'b1000;
    ack_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_grant", 32'(grant_o), 32'd0);
      chk("stray_cyc", 32'(cyc_o), 32'd0);
      chk("stray_ack", 32'(req_ack_o), 32'd0);
    end
    @(posedge clk); #1;
    req_stb_i = '0;
    ack_i     = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    // Requester 3 never gets an ack: 16 granted cycles, then one abort cycle
    do_reset();
    @(posedge clk); #1;
    req_dat_i = 32'h7700_0088;
    req_cyc_i = 4'b1000;
    req_stb_i = 4'b1000;
    q_grant.push_back(4'b1000);
    q_grant.push_back(4'b0001);
    wait_grant(4);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req_cyc_i = 4'b1001;
        req_stb_i = 4'b1001;
      end
      @(negedge clk);
      chk("wdog_no_err", 32'(req_err_o), 32'd0);
      chk("wdog_cyc", 32'(cyc_o), 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_err", 32'(req_err_o), 32'h8);
    chk("abort_cyc", 32'(cyc_o), 32'd0);
    chk("abort_stb", 32'(stb_o), 32'd0);
    chk("abort_stall", 32'(req_stall_o[3]), 32'd1);
    @(posedge clk); #1;
    req_cyc_i = 4'b0001;
    req_stb_i = 4'b0001;
    @(negedge clk);
    chk("abort_err_pulse", 32'(req_err_o), 32'd0);
    serve(0, 8'h88, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("grant_q_empty", 32'(q_grant.size()), 32'd0);
    chk("ack_q_empty", 32'(q_ack.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream Wishbone device among N_REQ upstream controllers.
- Typical downstream device is the byte FIFO's push port.
- Grant is locked for the whole upstream bus cycle (cyc held high); priority rotates on release.
- Pipelined Wishbone signalling (cyc/stb/stall/ack), single clock domain.

Parameters:
- N_REQ, 4, number of upstream controllers (2..16)
- DATA_WIDTH, 8, write data width
- TIMEOUT_CYCLES, 16, watchdog limit (used only with WB_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_cyc_i  in  N_REQ  per-requester cyc
- req_stb_i  in  N_REQ  per-requester stb
- req_dat_i  in  N_REQ*DATA_WIDTH  packed write data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_stall_o  out  N_REQ  per-requester stall
- req_ack_o  out  N_REQ  per-requester ack
- req_err_o  out  N_REQ  per-requester err (timeout abort)
- cyc_o  out  1  downstream cyc
- stb_o  out  1  downstream stb
- dat_o  out  DATA_WIDTH  downstream write data
- stall_i  in  1  downstream stall
- ack_i  in  1  downstream ack
- grant_o  out  N_REQ  registered one-hot grant (debug/status)

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - state=IDLE, grant_o=0, priority pointer=0, watchdog=0.
  - cyc_o=0, stb_o=0, dat_o=0.
  - req_ack_o=0, req_err_o=0.
  - req_stall_o = req_cyc_i & req_stb_i (every active strobe is stalled).
- States: IDLE, GRANTED.
- IDLE:
  - If any req_cyc_i is high, the next edge registers a one-hot grant to the first requesting index at or after the pointer, wrapping modulo N_REQ; go to GRANTED.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle: downstream cyc_o rises the cycle after the request.
- GRANTED (granted index g):
  - cyc_o = req_cyc_i[g]; stb_o = req_stb_i[g]; dat_o = slice g of req_dat_i. All combinational.
  - req_stall_o[g] = stall_i; req_ack_o[g] = ack_i; all acks are combinational pass-through.
  - Non-granted k: req_stall_o[k] = req_cyc_i[k] & req_stb_i[k]; req_ack_o[k] = 0.
  - Release: when req_cyc_i[g] is low, the next edge sets pointer=(g+1) mod N_REQ, grant_o=0 and state=IDLE.
  - Release-to-regrant takes 2 cycles: one IDLE cycle, during which cyc_o=0, guarantees a bus-idle gap.
- A requester holding cyc indefinitely keeps the grant; starvation prevention relies on the optional feature.
- Simultaneous requests are resolved purely by the pointer. Example: pointer=2, requests {0,3} -> grant 3.
- ack_i while cyc_o=0: ignored, not forwarded.
- stb without cyc from any requester: ignored for arbitration purposes.
- Reset mid-cycle: grant is dropped immediately; the downstream sees cyc_o fall asynchronously.
- Without WB_ARB_TIMEOUT_EN: req_err_o is constant 0.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - In GRANTED, the watchdog counts cycles with cyc_o=1 and ack_i=0; it clears on ack_i and on entering IDLE.
  - When the count reaches TIMEOUT_CYCLES, arbiter moves to ABORT for 1 cycle:
    - cyc_o=0, stb_o=0.
    - req_err_o[g]=1 for exactly that cycle.
    - req_stall_o[g]=1.
  - Then IDLE, with the pointer advanced past g.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter, no ABORT state, req_err_o tied 0.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, GRANTED, ABORT) and the index-width helper ($clog2-based) constant function.
- Sub-module rr_pick: combinational round-robin chooser. Inputs: request vector and pointer. Outputs: one-hot pick and valid flag. Parameterised by N_REQ.

Test Plan:
- Reset/idle: release rst_n with no requests -> cyc_o=0, grant_o=0. Raise req_cyc_i[1] with stb -> grant_o=4'b0010 next edge, cyc_o=1 same cycle as grant.
- Single transfer: requester 1 writes 8'hA5, downstream stalls 2 cycles then acks -> req_stall_o[1] high for 2 cycles, dat_o=8'hA5, one req_ack_o[1] pulse, no ack elsewhere.
- Round-robin fairness: all four requesters hold cyc, each drops cyc after its ack -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Contention stall: grant=0 while requester 2 strobes -> req_stall_o[2]=1 throughout; requester 2 is granted immediately after requester 0 releases (pointer=1, no request at 1).
- Async reset mid-transfer: drop rst_n while grant=2 and cyc_o=1 -> cyc_o, grant_o and req_ack_o go 0 without a clock edge; after release the pointer is 0.
- Timeout (macro on, TIMEOUT_CYCLES=16): granted requester 3, downstream never acks -> after 16 cycles, 1-cycle req_err_o[3] pulse with cyc_o=0, then next waiting requester granted.
